// File: rtl/step_segment_sequencer.sv
// Pops 4-word motion records from the record FIFO and plays each one out as a
// timed step pulse train with direction. Optional: STEP_SEGMENT_SEQUENCER_UNDERRUN_COUNT_EN.
module step_segment_sequencer #(
    parameter int unsigned WORD_SIZE    = 8,
    parameter int unsigned RECORD_WORDS = 4,
    parameter int unsigned PULSE_WIDTH  = 16,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 abort,
    input  logic                 fifo_empty,
    input  logic [WORD_SIZE-1:0] fifo_data,
    output logic                 fifo_read_en,
    output logic                 step,
    output logic                 dir,
    output logic                 busy,
    output logic                 underrun,
    output logic                 seg_done
`ifdef STEP_SEGMENT_SEQUENCER_UNDERRUN_COUNT_EN
    ,
    output logic [7:0]           underrun_count,
    input  logic                 clear_count
`endif
);

    localparam int unsigned RD_W = $clog2(RECORD_WORDS + 1);
    localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2 * PULSE_WIDTH);
    localparam logic [PERIOD_WIDTH-1:0] PULSE_LEN  = PERIOD_WIDTH'(PULSE_WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]              state, state_n;
    logic [RD_W-1:0]         rd_cnt, rd_cnt_n;
    logic                    dir_w, dir_w_n;
    logic                    last_w, last_w_n;
    logic                    last_r, last_r_n;
    logic [WORD_SIZE-1:0]    p_lo, p_lo_n;
    logic [PERIOD_WIDTH-1:0] pe_r, pe_n;
    logic [PERIOD_WIDTH-1:0] pcnt, pcnt_n;
    logic [7:0]              scnt, scnt_n;
    logic                    lead, lead_n;
    logic                    abort_pend, abort_pend_n;
    logic                    dir_n, step_n, read_en_n, underrun_n, seg_done_n;
    logic [PERIOD_WIDTH-1:0] p_full;

    // State register plus registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            dir_w        <= 1'b0;
            last_w       <= 1'b0;
            last_r       <= 1'b0;
            p_lo         <= '0;
            pe_r         <= '0;
            pcnt         <= '0;
            scnt         <= '0;
            lead         <= 1'b0;
            abort_pend   <= 1'b0;
            dir          <= 1'b0;
            step         <= 1'b0;
            fifo_read_en <= 1'b0;
            underrun     <= 1'b0;
            seg_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            rd_cnt       <= rd_cnt_n;
            dir_w        <= dir_w_n;
            last_w       <= last_w_n;
            last_r       <= last_r_n;
            p_lo         <= p_lo_n;
            pe_r         <= pe_n;
            pcnt         <= pcnt_n;
            scnt         <= scnt_n;
            lead         <= lead_n;
            abort_pend   <= abort_pend_n;
            dir          <= dir_n;
            step         <= step_n;
            fifo_read_en <= read_en_n;
            underrun     <= underrun_n;
            seg_done     <= seg_done_n;
            busy         <= (state_n != IDLE);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        rd_cnt_n     = rd_cnt;
        dir_w_n      = dir_w;
        last_w_n     = last_w;
        last_r_n     = last_r;
        p_lo_n       = p_lo;
        pe_n         = pe_r;
        pcnt_n       = pcnt;
        scnt_n       = scnt;
        lead_n       = lead;
        abort_pend_n = abort_pend;
        dir_n        = dir;
        step_n       = 1'b0;
        read_en_n    = 1'b0;
        underrun_n   = 1'b0;
        seg_done_n   = 1'b0;
        p_full       = PERIOD_WIDTH'({fifo_data, p_lo});

        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_n      = FETCH;
                    read_en_n    = 1'b1;
                    rd_cnt_n     = '0;
                    abort_pend_n = 1'b0;
                end
            end
            FETCH: begin
                // Reads always run to completion so the FIFO stays record-aligned
                rd_cnt_n = rd_cnt + RD_W'(1);
                if (abort) abort_pend_n = 1'b1;
                if (rd_cnt == RD_W'(1)) begin
                    dir_w_n  = fifo_data[0];
                    last_w_n = fifo_data[7];
                end else if (rd_cnt == RD_W'(2)) begin
                    scnt_n = 8'(fifo_data);
                end else if (rd_cnt == RD_W'(3)) begin
                    p_lo_n = fifo_data;
                end
                if (rd_cnt == RD_W'(RECORD_WORDS - 1)) state_n = LOAD;
                else read_en_n = 1'b1;
            end
            LOAD: begin
                if (abort || abort_pend) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                end else begin
                    state_n  = RUN;
                    dir_n    = dir_w;
                    last_r_n = last_w;
                    pe_n     = (p_full > MIN_PERIOD) ? p_full : MIN_PERIOD;
                    pcnt_n   = '0;
                    lead_n   = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                    pcnt_n  = '0;
                    lead_n  = 1'b0;
                end else if (lead) begin
                    // One setup cycle after dir changes, then the first period starts
                    lead_n = 1'b0;
                    pcnt_n = pe_r - PERIOD_WIDTH'(1);
                    step_n = (scnt != 8'd0);
                end else if (pcnt != '0) begin
                    pcnt_n     = pcnt - PERIOD_WIDTH'(1);
                    step_n     = (scnt != 8'd0) && ((pe_r - pcnt) < PULSE_LEN);
                    seg_done_n = (pcnt == PERIOD_WIDTH'(1)) && (scnt <= 8'd1);
                end else if (scnt > 8'd1) begin
                    scnt_n = scnt - 8'd1;
                    pcnt_n = pe_r - PERIOD_WIDTH'(1);
                    step_n = 1'b1;
                end else begin
                    scnt_n = '0;
                    if (enable && !fifo_empty) begin
                        state_n      = FETCH;
                        read_en_n    = 1'b1;
                        rd_cnt_n     = '0;
                        abort_pend_n = 1'b0;
                    end else begin
                        state_n    = IDLE;
                        underrun_n = !last_r && enable;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef STEP_SEGMENT_SEQUENCER_UNDERRUN_COUNT_EN
    // Saturating underrun event counter; a coincident clear wins
    always_ff @(posedge clk) begin
        if (reset)
            underrun_count <= '0;
        else if (clear_count)
            underrun_count <= '0;
        else if (underrun && (underrun_count != 8'hFF))
            underrun_count <= underrun_count + 8'd1;
    end
`endif

endmodule
